// File: rtl/bcd_disp_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bcd_disp_pkg
// Brief   : Segment encodings and helpers shared by the BCD display multiplexer.
// Revision: 1.0
//------------------------------------------------------------------------------
package bcd_disp_pkg;

   localparam int SEG_W = 7;

   // Bit positions within seg, ordered {g,f,e,d,c,b,a}
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'(1 << SEG_G);
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   function automatic logic nibble_invalid(input logic [3:0] nib);
      return nib > 4'd9;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_display_mux_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bcd_display_mux_if
// Brief   : Counter-side capture bus and board-side display bus of the mux.
// Revision: 1.0
//------------------------------------------------------------------------------
interface bcd_display_mux_if
   import bcd_disp_pkg::*;
#(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] bcd_in;
   logic                load;
   logic [SEG_W-1:0]    seg;
   logic [DIGITS-1:0]   an;
   logic                err;

   modport master (output bcd_in, load, input  seg, an, err);
   modport slave  (input  bcd_in, load, output seg, an, err);
endinterface
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bcd_to_seg
// Brief   : Combinational nibble to seven-segment decoder; non-BCD shows a dash.
// Revision: 1.0
//------------------------------------------------------------------------------
module bcd_to_seg
   import bcd_disp_pkg::*;
(
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bcd_display_mux.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bcd_display_mux
// Brief   : Captures packed BCD digits and scans them round-robin onto a
//           multiplexed seven-segment display with leading-zero blanking.
// Revision: 1.0
//------------------------------------------------------------------------------
module bcd_display_mux
   import bcd_disp_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 4,
   parameter int LZ_BLANK = 1
) (
   input  logic              clk,
   input  logic              reset,
   bcd_display_mux_if.slave  bus
);

   localparam int P_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int D_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [P_W-1:0] P_LAST = P_W'(SCAN_DIV - 1);
   localparam logic [D_W-1:0] D_LAST = D_W'(DIGITS - 1);

   logic [4*DIGITS-1:0] disp_q, disp_d;
   logic                err_q, err_d;
   logic [P_W-1:0]      p_q, p_d;
   logic [D_W-1:0]      d_q, d_d;
   logic [SEG_W-1:0]    seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic [DIGITS-1:0]   blank;
   logic                blank_run;
   logic [3:0]          nib;
   logic                nib_blank;
   logic [SEG_W-1:0]    dec_seg;

   always_comb begin
      disp_d = disp_q;
      err_d  = err_q;
      if (bus.load) begin
         disp_d = bus.bcd_in;
         err_d  = 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            if (nibble_invalid(bus.bcd_in[4*i +: 4])) begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      p_d = p_q + P_W'(1);
      d_d = d_q;
      if (p_q == P_LAST) begin
         p_d = '0;
         d_d = (d_q == D_LAST) ? '0 : d_q + D_W'(1);
      end
   end

   // Blanking propagates down from the most significant digit; digit 0 never blanks.
   always_comb begin
      blank     = '0;
      blank_run = (LZ_BLANK != 0);
      for (int i = DIGITS - 1; i >= 1; i--) begin
         blank_run = blank_run && (disp_q[4*i +: 4] == 4'd0);
         blank[i]  = blank_run;
      end
   end

   always_comb begin
      nib       = '0;
      nib_blank = 1'b0;
      an_d      = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (d_q == D_W'(i)) begin
            nib       = disp_q[4*i +: 4];
            nib_blank = blank[i];
            an_d[i]   = 1'b1;
         end
      end
   end

   bcd_to_seg u_dec (
      .nibble (nib),
      .seg    (dec_seg)
   );

   always_comb begin
      seg_d = nib_blank ? SEG_BLANK : dec_seg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_q <= '0;
         err_q  <= 1'b0;
         p_q    <= '0;
         d_q    <= '0;
         seg_q  <= SEG_0;
         an_q   <= DIGITS'(1);
      end else begin
         disp_q <= disp_d;
         err_q  <= err_d;
         p_q    <= p_d;
         d_q    <= d_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
      end
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;
   assign bus.err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_mux.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_bcd_display_mux
// Brief   : Directed self-checking bench for bcd_display_mux.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_bcd_display_mux;

   logic        clk;
   logic        reset;
   logic [15:0] bcd_in;
   logic        load;

   int errors = 0;
   int checks = 0;
   int k      = 0;   // edges since the last reset release

   bcd_display_mux_if #(.DIGITS(4)) bus0 ();
   bcd_display_mux_if #(.DIGITS(4)) bus1 ();
   bcd_display_mux_if #(.DIGITS(2)) bus2 ();

   assign bus0.bcd_in = bcd_in;
   assign bus0.load   = load;
   assign bus1.bcd_in = bcd_in;
   assign bus1.load   = load;
   assign bus2.bcd_in = bcd_in[7:0];
   assign bus2.load   = load;

   bcd_display_mux #(.DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1)) u_lz (
      .clk (clk), .reset (reset), .bus (bus0.slave));
   bcd_display_mux #(.DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(0)) u_nolz (
      .clk (clk), .reset (reset), .bus (bus1.slave));
   bcd_display_mux #(.DIGITS(2), .SCAN_DIV(1), .LZ_BLANK(1)) u_fast (
      .clk (clk), .reset (reset), .bus (bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_load(input logic [15:0] v);
      bcd_in = v;
      load   = 1'b1;
      tick();
      load   = 1'b0;
   endtask

   // After edge k the shown digit is ((k-1)/4)%4 (main units) and (k-1)%2 (fast unit).
   task automatic run_frame(input string tag, input int n,
                            input logic [3:0][6:0] exp_lz, input logic [3:0][6:0] exp_nolz);
      int dig;
      for (int t = 0; t < n; t++) begin
         tick();
         dig = ((k - 1) / 4) % 4;
         check($sformatf("%s_an_k%0d", tag, k), 16'(bus0.an), 16'(4'b0001 << dig));
         check($sformatf("%s_seg_lz_k%0d", tag, k), 16'(bus0.seg), 16'(exp_lz[dig]));
         check($sformatf("%s_seg_nolz_k%0d", tag, k), 16'(bus1.seg), 16'(exp_nolz[dig]));
         check($sformatf("%s_fast_an_k%0d", tag, k), 16'(bus2.an), 16'(2'b01 << ((k - 1) % 2)));
      end
   endtask

   initial begin
      reset  = 1'b1;
      load   = 1'b0;
      bcd_in = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_seg", 16'(bus0.seg), 16'h003F);
      check("rst_an",  16'(bus0.an),  16'h0001);
      check("rst_err", 16'(bus0.err), 16'h0000);
      check("rst_fast_an", 16'(bus2.an), 16'h0001);
      reset = 1'b0;
      k     = 0;

      // Zero value: digit 0 shows 0, upper digits blank; also covers the scan wrap
      run_frame("zero", 17, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F});

      do_load(16'h1905);
      check("err_1905", 16'(bus0.err), 16'h0000);
      run_frame("v1905", 16, {7'h06, 7'h6F, 7'h3F, 7'h6D}, {7'h06, 7'h6F, 7'h3F, 7'h6D});

      do_load(16'h0070);
      run_frame("v0070", 16, {7'h00, 7'h00, 7'h07, 7'h3F}, {7'h3F, 7'h3F, 7'h07, 7'h3F});

      do_load(16'h00A3);
      check("err_00A3", 16'(bus0.err), 16'h0001);
      run_frame("v00A3", 16, {7'h00, 7'h00, 7'h40, 7'h4F}, {7'h3F, 7'h3F, 7'h40, 7'h4F});

      do_load(16'h0042);
      check("err_0042", 16'(bus0.err), 16'h0000);
      run_frame("v0042", 16, {7'h00, 7'h00, 7'h66, 7'h5B}, {7'h3F, 7'h3F, 7'h66, 7'h5B});

      // Load while digit 0 is shown with p=2
      for (int t = 0; t < 16 && (k % 16) != 2; t++) tick();
      check("mid_align", 16'(k % 16), 16'd2);
      bcd_in = 16'h0008;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      check("mid_old_seg", 16'(bus0.seg), 16'h005B);
      tick();
      check("mid_new_seg", 16'(bus0.seg), 16'h007F);
      check("mid_new_an",  16'(bus0.an),  16'h0001);
      tick();
      check("mid_next_an",      16'(bus0.an),  16'h0002);
      check("mid_next_seg_lz",  16'(bus0.seg), 16'h0000);
      check("mid_next_seg_nolz", 16'(bus1.seg), 16'h003F);

      // Load held high recaptures each cycle
      bcd_in = 16'h00B0;
      load   = 1'b1;
      tick();
      check("held_err_a", 16'(bus0.err), 16'h0001);
      bcd_in = 16'h0010;
      tick();
      check("held_err_b", 16'(bus0.err), 16'h0000);
      bcd_in = 16'h00B0;
      tick();
      check("held_err_c", 16'(bus0.err), 16'h0001);
      load = 1'b0;
      bcd_in = 16'h0000;
      tick();
      check("err_hold", 16'(bus0.err), 16'h0001);

      // Asynchronous reset between edges while digit 2 is shown
      for (int t = 0; t < 16 && (k % 16) != 10; t++) tick();
      check("ar_pre_an", 16'(bus0.an), 16'h0004);
      #3;
      reset = 1'b1;
      #1;
      check("ar_an",  16'(bus0.an),  16'h0001);
      check("ar_seg", 16'(bus0.seg), 16'h003F);
      check("ar_err", 16'(bus0.err), 16'h0000);
      check("ar_fast_an", 16'(bus2.an), 16'h0001);
      reset = 1'b0;
      k     = 0;
      run_frame("post_rst", 5, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd_display_mux.md
# bcd_display_mux

Multiplexed seven-segment display driver that consumes the 4-bit BCD count produced by the cascaded decade-counter stage (one nibble per digit) and drives a common-anode-agnostic, active-high segment and digit-enable bus. It captures the packed counter outputs on a load strobe, scans the digits round-robin at a programmable rate, blanks leading zeros, and flags non-BCD input. It sits directly downstream of the decade counters and is the last stage before the board pins.

## Interface

- DIGITS, 4, number of BCD digits; digit 0 is least significant; legal range 1–8.
- SCAN_DIV, 4, clock cycles each digit is enabled; legal range 1 to 2^16.
- LZ_BLANK, 1, 1 = leading-zero blanking enabled, 0 = all digits always shown.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- bcd_in  input  4*DIGITS  packed BCD digits; digit i occupies bits [4i+3:4i].
- load  input  1  capture strobe; bcd_in is sampled on a rising edge where load=1.
- seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}, 1 = lit.
- an  output  DIGITS  one-hot digit enable, 1 = enabled.
- err  output  1  high while the captured value contains a nibble > 9.

## Operation

- Capture register disp[4*DIGITS-1:0]: loads bcd_in on an edge with load=1; otherwise holds. Loading never disturbs the scan.
- err: on a load edge, set to 1 if any nibble of bcd_in > 9, else cleared to 0. Holds between loads.
- Prescaler p counts 0..SCAN_DIV-1 and wraps. When p = SCAN_DIV-1, digit index d advances; when d = DIGITS-1, d wraps to 0.
- Decode: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F (hex, gfedcba). Nibbles 10–15 decode to dash, 40.
- Blanking: when LZ_BLANK=1, digit i (i ≥ 1) shows 00 if it and every more-significant digit equal 0. Digit 0 is never blanked. Invalid nibbles count as non-zero.
- an is the one-hot encoding of d. It remains asserted even for a blanked digit.
- Reset values: disp = 0, p = 0, d = 0, err = 0, an = one-hot bit 0, seg = 3F.

## Timing

- seg and an are registered. Each is a function of (d, disp) sampled at the same edge, so it lags d by one cycle.
- Each digit is enabled for exactly SCAN_DIV consecutive cycles. A full frame is DIGITS*SCAN_DIV cycles.
- Load at edge N:
  - disp and err update at edge N.
  - If the current digit is affected, seg reflects the new value at edge N+1.
- SCAN_DIV = 1: d advances every cycle. an is never all-zero and never multi-hot.
- DIGITS = 1: d stays 0; an is constantly 1.
- load held high: disp recaptures every cycle.
- Reset asserted mid-scan or mid-load: all state returns to its reset value immediately.
- First edge after reset deassertion: p becomes 1, d stays 0, outputs remain 3F / one-hot bit 0.

## Structure

- Package bcd_disp_pkg holds:
  - the segment constants SEG_0..SEG_9, SEG_DASH (40), SEG_BLANK (00);
  - the bit-order constants for seg.
- Sub-module bcd_to_seg: purely combinational nibble → 7-bit decoder, instantiated once on the muxed digit.
- Top level holds the capture register, prescaler, digit counter, blanking logic and output registers.

## Test plan

- **Reset:** reset=1 then release, no load. Expect seg=3F, an=0001, err=0. With defaults, d advances every 4 cycles, giving an = 0001,0010,0100,1000,0001.
- **Capture and decode:** load bcd_in=16'h1905. Across one 16-cycle frame, expect seg = 6D / 3F / 6F / 06 for an = 0001 / 0010 / 0100 / 1000.
- **Leading-zero blanking:**
  - bcd_in=16'h0070, LZ_BLANK=1: expect seg = 3F, 07, 00, 00 for digits 0–3.
  - Same value with LZ_BLANK=0: digits 2–3 show 3F.
  - bcd_in=16'h0000: digit 0 shows 3F, others 00.
- **Invalid nibble:** load 16'h00A3. Expect err=1, digit 1 shows 40, digits 2–3 blanked. Then load 16'h0042: err returns to 0.
- **Load mid-digit:** while an=0001 at p=2, load 16'h0008. Expect seg=7F on the next edge, with the scan phase unchanged (digit 0 still ends after p=3).
- **Async reset mid-scan:** assert reset between edges while an=0100. Expect an=0001, seg=3F, err=0 before the next clock edge.
